// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types and constants for the AES block-load controller
//                (FSM state encoding, block geometry, block-type tags).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Block geometry: four 32-bit words make one 128-bit AES block
  localparam int         WORDS_PER_BLOCK = 4;
  localparam logic [1:0] LAST_IDX        = 2'(WORDS_PER_BLOCK - 1);

  // Block-type tag carried on cmd_key with the first word of a block
  localparam logic CMD_KEY  = 1'b1;
  localparam logic CMD_TEXT = 1'b0;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_word_collect.sv
`default_nettype none
// ============================================================================
//  Module      : aes_word_collect
//  Description : Assembles four 32-bit words into a 128-bit block, first word
//                in the most significant slot. Flags the cycle on which the
//                fourth word arrives and presents the complete block then.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_word_collect
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_word_in,
  input  logic         i_word_valid_gated,
  input  logic         i_clear,
  output logic [127:0] o_block,
  output logic         o_last_word
);

  logic [1:0]   r_cnt;
  logic [127:0] r_block;
  logic [127:0] w_block;

  // Merge the incoming word into its slot so the whole block is visible on the 4th-word cycle
  always_comb begin
    w_block = r_block;
    if (i_word_valid_gated) begin
      case (r_cnt)
        2'd0: w_block[127:96] = i_word_in;
        2'd1: w_block[95:64]  = i_word_in;
        2'd2: w_block[63:32]  = i_word_in;
        2'd3: w_block[31:0]   = i_word_in;
        default: w_block = r_block;
      endcase
    end
  end

  assign o_block     = w_block;
  assign o_last_word = i_word_valid_gated && (r_cnt == LAST_IDX);

  // Word counter wraps to zero after the last word, so the next block starts fresh
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt   <= '0;
      r_block <= '0;
    end else if (i_word_valid_gated) begin
      r_cnt   <= r_cnt + 2'd1;
      r_block <= w_block;
    end
  end

endmodule : aes_word_collect
`default_nettype wire

// File: rtl/aes_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_load_ctrl
//  Description : Sequencing controller between the 8-to-32 input port and an
//                AES-128 core. Gathers 128-bit blocks, loads keys, starts one
//                encryption per plaintext block, watches for core completion
//                or timeout, and flags host words dropped while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_load_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  input  logic         cmd_key,
  output logic [127:0] key_out,
  output logic         key_load,
  output logic [127:0] text_out,
  output logic         core_start,
  input  logic         core_done,
  output logic         busy,
  output logic         err_nokey,
  output logic         err_timeout,
  output logic         overrun
);

  // Last counter value before the core is declared unresponsive
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_blk_is_key;
  logic           r_key_valid;
  logic [15:0]    r_tmo_cnt;

  logic [127:0]   r_key_out;
  logic [127:0]   r_text_out;
  logic           r_key_load;
  logic           r_core_start;
  logic           r_busy;
  logic           r_err_nokey;
  logic           r_err_timeout;
  logic           r_overrun;

  logic           w_word_valid_gated;
  logic           w_clear;
  logic [127:0]   w_block;
  logic           w_last_word;

  logic           w_key_we;
  logic           w_text_we;
  logic           w_key_load_nxt;
  logic           w_core_start_nxt;
  logic           w_err_nokey_nxt;
  logic           w_err_timeout_nxt;
  logic           w_busy_nxt;
  logic           w_key_valid_nxt;
  logic           w_tmo_clr;
  logic           w_overrun_set;

  // Words arriving while the core is working are not assembled
  assign w_word_valid_gated = word_valid && (r_state != WAIT_DONE);
  assign w_clear            = (r_state == WAIT_DONE);

  aes_word_collect u_collect (
    .clk                (clk),
    .rst                (rst),
    .i_word_in          (word_in),
    .i_word_valid_gated (w_word_valid_gated),
    .i_clear            (w_clear),
    .o_block            (w_block),
    .o_last_word        (w_last_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the next values of the pulse/status registers
  always_comb begin
    w_state_nxt       = r_state;
    w_key_we          = 1'b0;
    w_text_we         = 1'b0;
    w_key_load_nxt    = 1'b0;
    w_core_start_nxt  = 1'b0;
    w_err_nokey_nxt   = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_busy_nxt        = r_busy;
    w_key_valid_nxt   = r_key_valid;
    w_tmo_clr         = 1'b0;
    w_overrun_set     = 1'b0;

    case (r_state)
      IDLE: begin
        if (word_valid) begin
          w_state_nxt = COLLECT;
        end
      end

      COLLECT: begin
        if (w_last_word) begin
          if (r_blk_is_key == CMD_KEY) begin
            w_key_we        = 1'b1;
            w_key_load_nxt  = 1'b1;
            w_key_valid_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else if (r_key_valid) begin
            w_text_we        = 1'b1;
            w_core_start_nxt = 1'b1;
            w_busy_nxt       = 1'b1;
            w_tmo_clr        = 1'b1;
            w_state_nxt      = WAIT_DONE;
          end else begin
            // Plaintext with no key: discard the block, leave text_out alone
            w_err_nokey_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        // Any host word here is lost, even on the core_done cycle
        if (word_valid) begin
          w_overrun_set = 1'b1;
        end
        if (core_done) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_err_timeout_nxt = 1'b1;
          w_busy_nxt        = 1'b0;
          w_state_nxt       = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Block-type tag is taken only from the first word of a block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_is_key <= CMD_TEXT;
    end else if ((r_state == IDLE) && word_valid) begin
      r_blk_is_key <= cmd_key;
    end
  end

  // Timeout counter: zero on the first WAIT_DONE cycle, counts while waiting
  always_ff @(posedge clk) begin
    if (rst || w_tmo_clr) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Key/text holding registers, pulses, busy and the sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_out     <= '0;
      r_text_out    <= '0;
      r_key_valid   <= 1'b0;
      r_key_load    <= 1'b0;
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_err_nokey   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_key_we) begin
        r_key_out <= w_block;
      end
      if (w_text_we) begin
        r_text_out <= w_block;
      end
      r_key_valid   <= w_key_valid_nxt;
      r_key_load    <= w_key_load_nxt;
      r_core_start  <= w_core_start_nxt;
      r_busy        <= w_busy_nxt;
      r_err_nokey   <= w_err_nokey_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign key_out     = r_key_out;
  assign key_load    = r_key_load;
  assign text_out    = r_text_out;
  assign core_start  = r_core_start;
  assign busy        = r_busy;
  assign err_nokey   = r_err_nokey;
  assign err_timeout = r_err_timeout;
  assign overrun     = r_overrun;

endmodule : aes_load_ctrl
`default_nettype wire

// File: tb/tb_aes_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_load_ctrl
//  Description : Self-checking bench for aes_load_ctrl. Two instances share
//                stimulus: dut_a uses the default timeout, dut_b a short one.
//                Output events of dut_a are matched against a queue of
//                expected events built from a small reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_load_ctrl;

  localparam int T_A = 64;
  localparam int T_B = 8;

  localparam int EV_KEYLOAD = 1;
  localparam int EV_START   = 2;
  localparam int EV_NOKEY   = 3;
  localparam int EV_TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         cmd_key;
  logic         core_done;

  logic [127:0] key_out_a, text_out_a, key_out_b, text_out_b;
  logic         key_load_a, core_start_a, busy_a, err_nokey_a, err_timeout_a, overrun_a;
  logic         key_load_b, core_start_b, busy_b, err_nokey_b, err_timeout_b, overrun_b;

  aes_load_ctrl #(.TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .cmd_key(cmd_key),
    .key_out(key_out_a), .key_load(key_load_a), .text_out(text_out_a),
    .core_start(core_start_a), .core_done(core_done), .busy(busy_a),
    .err_nokey(err_nokey_a), .err_timeout(err_timeout_a), .overrun(overrun_a)
  );

  aes_load_ctrl #(.TIMEOUT_CYCLES(T_B)) dut_b (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .cmd_key(cmd_key),
    .key_out(key_out_b), .key_load(key_load_b), .text_out(text_out_b),
    .core_start(core_start_b), .core_done(core_done), .busy(busy_b),
    .err_nokey(err_nokey_b), .err_timeout(err_timeout_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    int           cyc;
    logic [127:0] data;
  } evt_t;

  evt_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic         m_key_valid;
  logic [127:0] m_key;
  logic [127:0] m_text;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_evt(input int kind, input int c, input logic [127:0] data);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_key_valid = 1'b0;
    m_key       = '0;
    m_text      = '0;
  endtask

  // Four back-to-back words; cmd_key is inverted on words 2..4 so only the first counts
  task automatic send_block(input logic [127:0] blk, input logic k);
    for (int i = 0; i < 4; i++) begin
      word_in    = blk[127 - 32*i -: 32];
      cmd_key    = (i == 0) ? k : ~k;
      word_valid = 1'b1;
      if (i == 3) begin
        if (k) begin
          m_key       = blk;
          m_key_valid = 1'b1;
          push_evt(EV_KEYLOAD, cyc + 1, blk);
        end else if (m_key_valid) begin
          m_text = blk;
          push_evt(EV_START, cyc + 1, blk);
        end else begin
          push_evt(EV_NOKEY, cyc + 1, m_text);
        end
      end
      tick();
    end
    word_valid = 1'b0;
    word_in    = '0;
    cmd_key    = 1'b0;
  endtask

  // Scoreboard: every pulse of dut_a must match the head of the expected queue
  always @(negedge clk) begin
    int           kind;
    logic [127:0] data;
    evt_t         e;
    if (key_load_a || core_start_a || err_nokey_a || err_timeout_a) begin
      kind = key_load_a ? EV_KEYLOAD : core_start_a ? EV_START : err_nokey_a ? EV_NOKEY : EV_TIMEOUT;
      data = key_load_a ? key_out_a : text_out_a;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_evt", kind, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("evt_kind", kind, e.kind);
        check_eq("evt_cycle", cyc, e.cyc);
        check_eq("evt_data", data, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_eq("missed_evt", exp_q[0].kind, 0);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int busy_cnt;

    rst = 1'b1; word_in = '0; word_valid = 1'b0; cmd_key = 1'b0; core_done = 1'b0;
    m_key_valid = 1'b0; m_key = '0; m_text = '0;

    // ---- Reset values ----
    tick(); tick();
    @(negedge clk);
    check_eq("rst_key_out", key_out_a, '0);
    check_eq("rst_text_out", text_out_a, '0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_overrun", overrun_a, 0);
    check_eq("rst_pulses", {key_load_a, core_start_a, err_nokey_a, err_timeout_a}, 0);
    core_done = 1'b1;   // core_done outside WAIT_DONE must be ignored
    tick();
    rst = 1'b0;
    tick();
    core_done = 1'b0;
    check_eq("idle_done_busy", busy_a, 0);

    // ---- Plaintext before any key ----
    send_block(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
    tick(); tick();
    @(negedge clk);
    check_eq("nokey_text_out", text_out_a, '0);
    check_eq("nokey_busy", busy_a, 0);

    // ---- Key then text, core_done on the 12th busy cycle ----
    send_block(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
    send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b0);
    s = cyc;
    busy_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      tick();
    end
    core_done = 1'b1;
    @(negedge clk);
    if (busy_a) busy_cnt++;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check_eq("busy_after_done", busy_a, 0);
    check_eq("busy_cycles", busy_cnt, 12);
    check_eq("key_out_k1", key_out_a, 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("text_out_p1", text_out_a, 128'h00112233445566778899AABBCCDDEEFF);
    check_eq("no_overrun_yet", overrun_a, 0);

    // ---- Overrun: one word mid-wait, one together with core_done ----
    send_block(128'h11111111_22222222_33333333_44444444, 1'b0);
    s = cyc;
    wait_until(s + 3);
    word_in = 32'h77777777; cmd_key = 1'b1; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    wait_until(s + 6);
    word_in = 32'h66666666; word_valid = 1'b1; core_done = 1'b1;
    tick();
    word_valid = 1'b0; core_done = 1'b0; cmd_key = 1'b0;
    @(negedge clk);
    check_eq("overrun_set", overrun_a, 1);
    check_eq("overrun_busy", busy_a, 0);
    send_block(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b0);
    s = cyc;
    wait_until(s + 2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check_eq("overrun_sticky", overrun_a, 1);
    check_eq("text_after_overrun", text_out_a, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);

    // ---- Key reload ----
    send_block(128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 1'b1);
    send_block(128'h3243F6A8_885A308D_313198A2_E0370734, 1'b0);
    s = cyc;
    wait_until(s + 4);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check_eq("key_reload", key_out_a, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C);
    check_eq("text_new_key", text_out_a, 128'h3243F6A8_885A308D_313198A2_E0370734);

    // ---- Reset mid-block ----
    check_eq("key_valid_before_rst", dut_a.r_key_valid, 1);
    word_in = 32'h99999999; cmd_key = 1'b1; word_valid = 1'b1;
    tick();
    word_in = 32'h88888888; cmd_key = 1'b0;
    tick();
    word_valid = 1'b0;
    reset_all();
    @(negedge clk);
    check_eq("rst_key_valid", dut_a.r_key_valid, 0);
    check_eq("rst_mid_key_out", key_out_a, '0);
    check_eq("rst_mid_overrun", overrun_a, 0);
    core_done = 1'b1;   // stray done right after reset
    tick();
    core_done = 1'b0;
    send_block(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 1'b1);
    @(negedge clk);
    check_eq("post_rst_key", key_out_a, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978);

    // ---- Timeout (dut_b, TIMEOUT_CYCLES = 8) ----
    reset_all();
    send_block(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 1'b1);
    send_block(128'hCAFEBABE_00000001_00000002_00000003, 1'b0);
    s = cyc;
    push_evt(EV_TIMEOUT, s + T_A, 128'hCAFEBABE_00000001_00000002_00000003);
    @(negedge clk);
    check_eq("tmo_b_start", core_start_b, 1);
    wait_until(s + T_B - 1);
    @(negedge clk);
    check_eq("tmo_b_early", err_timeout_b, 0);
    check_eq("tmo_b_busy_before", busy_b, 1);
    tick();
    @(negedge clk);
    check_eq("tmo_b_pulse", err_timeout_b, 1);
    check_eq("tmo_b_busy_low", busy_b, 0);
    check_eq("tmo_a_still_busy", busy_a, 1);
    tick();
    @(negedge clk);
    check_eq("tmo_b_single", err_timeout_b, 0);
    wait_until(s + T_A + 1);
    @(negedge clk);
    check_eq("tmo_a_busy_low", busy_a, 0);
    send_block(128'h0BADF00D_10203040_50607080_90A0B0C0, 1'b0);
    s = cyc;
    @(negedge clk);
    check_eq("tmo_b_restart", core_start_b, 1);
    check_eq("tmo_b_text", text_out_b, 128'h0BADF00D_10203040_50607080_90A0B0C0);
    wait_until(s + 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check_eq("final_busy", {busy_a, busy_b}, 0);

    tick(); tick();
    check_eq("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_aes_load_ctrl
`default_nettype wire
